vco_555_rc_lowpass: RTL and testbench

//  Discrete-audio source: behavioural 555 astable VCO whose square-wave output feeds a first-order RC low-pass filter.

---
 rtl/vco_555_rc_lowpass.sv | 246 ++++++++++++++++++++++++
 tb/tb_vco_555_rc_lowpass.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vco_555_rc_lowpass.sv
// ---------------------------------------------------------------------------
// vco_555_rc_lowpass
//
// Purpose
//   Behavioural 555 astable VCO whose square-wave output drives a first-order
//   RC low-pass filter. Both stages advance one step per audio_clk_en strobe,
//   and both the raw and the filtered waveform are exported to the mixer.
//
//   The timing capacitor voltage (v_cap) charges toward VCC with coefficient
//   K_CHG and discharges toward ground with K_DIS. The thresholds follow the
//   555 control pin: upper = vc, lower = vc/2. Pulling v_control to zero or
//   below halts the oscillator: the phase is pinned to DISCHARGE, so v_cap
//   bleeds off and out stays at 0.
//
//   All coefficients are Q16 (65536 = 1.0) integers derived at elaboration
//   from the component values and the sample period dt = 1/SAMPLE_RATE.
//
// Ports
//   clk           in   1   system clock
//   reset         in   1   synchronous active-high reset, wins over the strobe
//   audio_clk_en  in   1   one-clk-wide sample strobe
//   v_control     in   16  signed control voltage, 32767 = VCC
//   out           out  16  signed raw VCO output (32767 or 0)
//   filtered_out  out  16  signed RC-filtered output
//
// Build option
//   VCO_LPF_DC_BLOCK_EN : when defined, a DC blocker follows the RC filter
//                         and filtered_out carries the blocked signal.
//
// Handshake
//   audio_clk_en is a plain enable: every rising clk edge that sees it high
//   advances one sample; outputs change only on those edges and hold between.
//
// FSM visibility
//   phase_q is the oscillator phase register (PH_CHARGE / PH_DISCHARGE);
//   monitors bind to it directly.
// ---------------------------------------------------------------------------
module vco_555_rc_lowpass #(
    parameter int unsigned CLOCK_RATE  = 50000000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned R1_OHM      = 1000,
    parameter int unsigned R2_OHM      = 10000,
    parameter int unsigned C_VCO_NF    = 100,
    parameter int unsigned R_LPF_OHM   = 10000,
    parameter int unsigned C_LPF_NF    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               audio_clk_en,
    input  logic signed [15:0] v_control,
    output logic signed [15:0] out,
    output logic signed [15:0] filtered_out
);

    // -----------------------------------------------------------------------
    // Elaboration-time checks and coefficients
    // -----------------------------------------------------------------------
    if (CLOCK_RATE < 2 * SAMPLE_RATE) begin : g_bad_rate
        $error("vco_555_rc_lowpass: CLOCK_RATE must be at least 2*SAMPLE_RATE");
    end

    // num/den clamped into the usable Q16 range [1, 65535].
    function automatic longint unsigned q16_coef(input longint unsigned num,
                                                 input longint unsigned den);
        longint unsigned q;
        if (den == 64'd0) q = 64'd65535;
        else              q = num / den;
        if (q < 64'd1)          q = 64'd1;
        else if (q > 64'd65535) q = 64'd65535;
        return q;
    endfunction

    // Capacitances are in nF, so 65536 * 1e9 carries both the Q16 scale and
    // the nano prefix: K = 65536 * dt / (R*C) = 65536e9 / (SR * R * C_nF).
    localparam longint unsigned Q16_NS  = 64'd65536 * 64'd1000000000;
    localparam longint unsigned DEN_CHG = 64'(SAMPLE_RATE) * 64'(R1_OHM + R2_OHM) * 64'(C_VCO_NF);
    localparam longint unsigned DEN_DIS = 64'(SAMPLE_RATE) * 64'(R2_OHM) * 64'(C_VCO_NF);
    // dt/(RC+dt) = 1 / (1 + SR*R*C) = 1e9 / (1e9 + SR*R*C_nF)
    localparam longint unsigned DEN_LPF = 64'(SAMPLE_RATE) * 64'(R_LPF_OHM) * 64'(C_LPF_NF)
                                          + 64'd1000000000;

    localparam int K_CHG = int'(q16_coef(Q16_NS, DEN_CHG));
    localparam int K_DIS = int'(q16_coef(Q16_NS, DEN_DIS));
    localparam int A_LPF = int'(q16_coef(Q16_NS, DEN_LPF));

    // Same coefficients as 17-bit signed multiplier operands (always positive).
    localparam logic signed [16:0] K_CHG_S = 17'(K_CHG);
    localparam logic signed [16:0] K_DIS_S = 17'(K_DIS);
    localparam logic signed [16:0] A_LPF_S = 17'(A_LPF);

    localparam logic signed [17:0] Y_MAX = 18'sd32767;
    localparam logic signed [17:0] Y_MIN = -18'sd32768;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic {
        PH_CHARGE    = 1'b0,
        PH_DISCHARGE = 1'b1
    } phase_t;

    phase_t             phase_q, phase_d;
    logic        [16:0] v_cap_q, v_cap_d;
    logic signed [15:0] out_q,   out_d;
    logic signed [17:0] y_q,     y_d;

    // -----------------------------------------------------------------------
    // Control voltage and thresholds
    // -----------------------------------------------------------------------
    logic        halt;
    logic [16:0] vc;
    logic [16:0] th;
    logic [16:0] tl;

    assign halt = (v_control <= 16'sd0);
    assign vc   = (v_control < 16'sd1024)  ? 17'd1024  :
                  (v_control > 16'sd31129) ? 17'd31129 :
                                             17'($unsigned(v_control));
    assign th   = vc;
    assign tl   = vc >> 1;

    // -----------------------------------------------------------------------
    // Charge step: v_cap += ((32767 - v_cap) * K_CHG) >> 16, minimum +1.
    // A non-positive headroom contributes nothing, leaving only the +1 floor.
    // -----------------------------------------------------------------------
    logic signed [17:0] chg_diff;
    logic signed [16:0] chg_opnd;
    logic signed [33:0] chg_prod;
    logic        [16:0] chg_raw;
    logic        [16:0] chg_step;
    logic        [17:0] chg_sum;
    logic        [16:0] chg_next;

    assign chg_diff = 18'sd32767 - $signed({1'b0, v_cap_q});
    assign chg_opnd = (chg_diff > 18'sd0) ? 17'(chg_diff) : 17'sd0;
    assign chg_prod = 34'(chg_opnd) * 34'(K_CHG_S);
    assign chg_raw  = 17'(chg_prod >>> 16);
    assign chg_step = (chg_raw == 17'd0) ? 17'd1 : chg_raw;
    assign chg_sum  = 18'(v_cap_q) + 18'(chg_step);
    assign chg_next = chg_sum[17] ? 17'h1FFFF : chg_sum[16:0];

    // -----------------------------------------------------------------------
    // Discharge step: v_cap -= (v_cap * K_DIS) >> 16, minimum -1 while > 0.
    // The operand is limited to the 17-bit signed range; v_cap never gets
    // near that bound because charging stops at the upper threshold.
    // -----------------------------------------------------------------------
    logic signed [16:0] dis_opnd;
    logic signed [33:0] dis_prod;
    logic        [16:0] dis_raw;
    logic        [16:0] dis_step;
    logic        [16:0] dis_next;

    assign dis_opnd = (v_cap_q > 17'd65535) ? 17'sd65535 : $signed(v_cap_q);
    assign dis_prod = 34'(dis_opnd) * 34'(K_DIS_S);
    assign dis_raw  = 17'(dis_prod >>> 16);
    assign dis_step = ((dis_raw == 17'd0) && (v_cap_q != 17'd0)) ? 17'd1 : dis_raw;
    assign dis_next = (dis_step > v_cap_q) ? 17'd0 : (v_cap_q - dis_step);

    // A halted oscillator keeps discharging regardless of the stored phase.
    assign v_cap_d = (halt || (phase_q == PH_DISCHARGE)) ? dis_next : chg_next;

    // -----------------------------------------------------------------------
    // Phase FSM: transitions look at the already-updated v_cap.
    // -----------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        if (halt) begin
            phase_d = PH_DISCHARGE;
        end else begin
            case (phase_q)
                PH_CHARGE:    if (v_cap_d >= th) phase_d = PH_DISCHARGE;
                PH_DISCHARGE: if (v_cap_d <= tl) phase_d = PH_CHARGE;
                default:      phase_d = PH_CHARGE;
            endcase
        end
    end

    assign out_d = (!halt && (phase_d == PH_CHARGE)) ? 16'sd32767 : 16'sd0;

    // -----------------------------------------------------------------------
    // RC low-pass: y += ((x - y) * A_LPF) >>> 16, x = the new out value, so
    // the filter responds in the same sample the square wave changes.
    // |x - y| <= 65535 because y is kept inside the 16-bit range.
    // -----------------------------------------------------------------------
    logic signed [16:0] flt_diff;
    logic signed [33:0] flt_prod;
    logic signed [17:0] flt_step;
    logic signed [18:0] flt_sum;

    assign flt_diff = 17'(18'(out_d) - y_q);
    assign flt_prod = 34'(flt_diff) * 34'(A_LPF_S);
    assign flt_step = 18'(flt_prod >>> 16);
    assign flt_sum  = 19'(y_q) + 19'(flt_step);
    assign y_d      = (flt_sum > 19'(Y_MAX)) ? Y_MAX :
                      (flt_sum < 19'(Y_MIN)) ? Y_MIN :
                                               18'(flt_sum);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_CHARGE;
            v_cap_q <= 17'd0;
            out_q   <= 16'sd0;
            y_q     <= 18'sd0;
        end else if (audio_clk_en) begin
            phase_q <= phase_d;
            v_cap_q <= v_cap_d;
            out_q   <= out_d;
            y_q     <= y_d;
        end
    end

    assign out = out_q;

`ifdef VCO_LPF_DC_BLOCK_EN
    // -----------------------------------------------------------------------
    // DC blocker: z = y - y_prev + z_prev - (z_prev >>> 8).
    // y_q is the previous filter sample at the moment y_d is formed, so it
    // serves as y_prev without a separate register.
    // -----------------------------------------------------------------------
    logic signed [15:0] z_q;
    logic signed [15:0] z_d;
    logic signed [19:0] dc_sum;

    assign dc_sum = 20'(y_d) - 20'(y_q) + 20'(z_q) - 20'(z_q >>> 8);
    assign z_d    = (dc_sum > 20'sd32767)  ? 16'sd32767  :
                    (dc_sum < -20'sd32768) ? -16'sd32768 :
                                             16'(dc_sum);

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q <= 16'sd0;
        end else if (audio_clk_en) begin
            z_q <= z_d;
        end
    end

    assign filtered_out = z_q;
`else
    // y is saturated to the 16-bit range, so the truncation is lossless.
    assign filtered_out = 16'(y_q);
`endif

endmodule

// File: tb/tb_vco_555_rc_lowpass.sv
// ---------------------------------------------------------------------------
// tb_vco_555_rc_lowpass
//
// Drives vco_555_rc_lowpass with sample strobes and compares its outputs with
// a behavioural model that steps the capacitor voltage, the phase and the
// filter state with plain integer arithmetic. Coefficients are derived from
// the component values with real arithmetic.
// ---------------------------------------------------------------------------
module tb_vco_555_rc_lowpass;

    localparam int unsigned CLOCK_RATE  = 50000000;
    localparam int unsigned SAMPLE_RATE = 48000;
    localparam int unsigned R1_OHM      = 1000;
    localparam int unsigned R2_OHM      = 10000;
    localparam int unsigned C_VCO_NF    = 100;
    localparam int unsigned R_LPF_OHM   = 10000;
    localparam int unsigned C_LPF_NF    = 10;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               reset;
    logic               audio_clk_en;
    logic signed [15:0] v_control;
    logic signed [15:0] out;
    logic signed [15:0] filtered_out;

    always #5 clk = ~clk;

    vco_555_rc_lowpass #(
        .CLOCK_RATE (CLOCK_RATE),
        .SAMPLE_RATE(SAMPLE_RATE),
        .R1_OHM     (R1_OHM),
        .R2_OHM     (R2_OHM),
        .C_VCO_NF   (C_VCO_NF),
        .R_LPF_OHM  (R_LPF_OHM),
        .C_LPF_NF   (C_LPF_NF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .audio_clk_en(audio_clk_en),
        .v_control   (v_control),
        .out         (out),
        .filtered_out(filtered_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int     k_chg, k_dis, a_lpf;
    longint m_vcap;
    bit     m_chg;
    longint m_out;
    longint m_y;
    longint m_z;

    function automatic int to_q16(input real v);
        real f;
        f = $floor(v * 65536.0);
        if (f < 1.0)     return 1;
        if (f > 65535.0) return 65535;
        return int'(f);
    endfunction

    function automatic void model_coefs();
        real dt, rc;
        dt    = 1.0 / real'(SAMPLE_RATE);
        k_chg = to_q16(dt / (real'(R1_OHM + R2_OHM) * real'(C_VCO_NF) * 1.0e-9));
        k_dis = to_q16(dt / (real'(R2_OHM) * real'(C_VCO_NF) * 1.0e-9));
        rc    = real'(R_LPF_OHM) * real'(C_LPF_NF) * 1.0e-9;
        a_lpf = to_q16(dt / (rc + dt));
    endfunction

    function automatic void model_reset();
        m_vcap = 0;
        m_chg  = 1'b1;
        m_out  = 0;
        m_y    = 0;
        m_z    = 0;
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_step(input int vctl);
        bit     halted;
        longint vc, d, y_old;
        halted = (vctl <= 0);
        vc = (vctl < 1024) ? 1024 : ((vctl > 31129) ? 31129 : vctl);
        if (halted || !m_chg) begin
            d = (m_vcap * k_dis) / 65536;
            if (d == 0 && m_vcap > 0) d = 1;
            m_vcap = m_vcap - d;
            if (m_vcap < 0) m_vcap = 0;
        end else begin
            d = 32767 - m_vcap;
            d = (d > 0) ? (d * k_chg) / 65536 : 0;
            if (d < 1) d = 1;
            m_vcap = m_vcap + d;
        end
        if (halted)                       m_chg = 1'b0;
        else if (m_chg && m_vcap >= vc)   m_chg = 1'b0;
        else if (!m_chg && m_vcap <= vc / 2) m_chg = 1'b1;
        m_out = m_chg ? 32767 : 0;
        y_old = m_y;
        m_y   = sat16(m_y + (((m_out - m_y) * a_lpf) >>> 16));
        m_z   = sat16(m_y - y_old + m_z - (m_z >>> 8));
    endfunction

    function automatic longint m_filt();
`ifdef VCO_LPF_DC_BLOCK_EN
        return m_z;
`else
        return m_y;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // One strobe (one clk wide), then 'gap' idle clocks. Returns #1 after an edge.
    task automatic strobe(input int gap);
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        if (reset) model_reset();
        else       model_step(int'(v_control));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        v_control = 16'sd20000;
        for (int i = 0; i < 5; i++) begin
            strobe(1);
            n_vec++;
            if (out !== 16'sd0) begin
                n_err++;
                $display("FAIL reset_out[%0d]: got %0d expected 0", i, out);
            end
            n_vec++;
            if (filtered_out !== 16'sd0) begin
                n_err++;
                $display("FAIL reset_filt[%0d]: got %0d expected 0", i, filtered_out);
            end
        end
        reset = 1'b0;
        strobe(1);
        n_vec++;
        if (out !== 16'sd32767) begin
            n_err++;
            $display("FAIL first_strobe_out: got %0d expected 32767", out);
        end
        n_vec++;
        if (filtered_out !== 16'(m_filt())) begin
            n_err++;
            $display("FAIL first_strobe_filt: got %0d expected %0d", filtered_out, m_filt());
        end
    endtask

    task automatic test_period();
        int d_rise = -1, d_period = 0, d_run = 0, d_hi = 0;
        int m_rise = -1, m_period = 0, m_run = 0, m_hi = 0;
        logic signed [15:0] d_prev;
        longint m_prev;
        d_prev    = out;
        m_prev    = m_out;
        v_control = 16'sd20000;
        for (int i = 0; i < 800; i++) begin
            strobe($urandom_range(0, 2));
            n_vec++;
            if (out !== 16'(m_out)) begin
                n_err++;
                $display("FAIL period_out[%0d]: got %0d expected %0d", i, out, m_out);
            end
            n_vec++;
            if (filtered_out !== 16'(m_filt())) begin
                n_err++;
                $display("FAIL period_filt[%0d]: got %0d expected %0d", i, filtered_out, m_filt());
            end
            if (out == 16'sd32767 && d_prev == 16'sd0) begin
                if (d_rise >= 0) d_period = i - d_rise;
                d_rise = i;
                d_run  = 0;
            end
            if (out == 16'sd32767) d_run++;
            else if (d_prev == 16'sd32767) d_hi = d_run;
            if (m_out == 32767 && m_prev == 0) begin
                if (m_rise >= 0) m_period = i - m_rise;
                m_rise = i;
                m_run  = 0;
            end
            if (m_out == 32767) m_run++;
            else if (m_prev == 32767) m_hi = m_run;
            d_prev = out;
            m_prev = m_out;
        end
        n_vec++;
        if (d_period !== m_period) begin
            n_err++;
            $display("FAIL period_len: got %0d expected %0d", d_period, m_period);
        end
        n_vec++;
        if (d_hi !== m_hi) begin
            n_err++;
            $display("FAIL period_high: got %0d expected %0d", d_hi, m_hi);
        end
        n_vec++;
        if (d_period < 55 || d_period > 80) begin
            n_err++;
            $display("FAIL period_range: got %0d expected 55..80", d_period);
        end
    endtask

    task automatic test_sweep();
        int levels[6] = '{32767, 30000, 25000, 15000, 5000, 1000};
        int prev_edges = 0;
        for (int s = 0; s < 6; s++) begin
            int edges = 0;
            logic signed [15:0] d_prev;
            d_prev    = out;
            v_control = 16'(levels[s]);
            for (int i = 0; i < 3000; i++) begin
                strobe(0);
                n_vec++;
                if (out !== 16'(m_out) || filtered_out !== 16'(m_filt())) begin
                    n_err++;
                    $display("FAIL sweep_%0d[%0d]: got out=%0d filt=%0d expected out=%0d filt=%0d",
                             levels[s], i, out, filtered_out, m_out, m_filt());
                end
                if (out == 16'sd32767 && d_prev == 16'sd0) edges++;
                d_prev = out;
            end
            n_vec++;
            if (s == 0) begin
                if (edges < 2) begin
                    n_err++;
                    $display("FAIL sweep_oscillates_32767: got %0d edges expected >= 2", edges);
                end
            end else if (edges <= prev_edges) begin
                n_err++;
                $display("FAIL sweep_monotonic_%0d: got %0d edges expected > %0d",
                         levels[s], edges, prev_edges);
            end
            prev_edges = edges;
        end
    endtask

    task automatic test_halt();
        int levels[2] = '{0, -1000};
        logic signed [15:0] f_prev;
        v_control = 16'sd20000;
        for (int i = 0; i < 100; i++) strobe($urandom_range(0, 1));
        for (int s = 0; s < 2; s++) begin
            v_control = 16'(levels[s]);
            strobe(0);
            n_vec++;
            if (out !== 16'sd0) begin
                n_err++;
                $display("FAIL halt_out_%0d: got %0d expected 0", levels[s], out);
            end
            f_prev = filtered_out;
            for (int i = 0; i < 150; i++) begin
                strobe($urandom_range(0, 1));
                n_vec++;
                if (out !== 16'(m_out) || filtered_out !== 16'(m_filt())) begin
                    n_err++;
                    $display("FAIL halt_model_%0d[%0d]: got out=%0d filt=%0d expected out=%0d filt=%0d",
                             levels[s], i, out, filtered_out, m_out, m_filt());
                end
`ifndef VCO_LPF_DC_BLOCK_EN
                n_vec++;
                if (filtered_out > f_prev || filtered_out < 16'sd0) begin
                    n_err++;
                    $display("FAIL halt_decay_%0d[%0d]: got %0d expected 0..%0d",
                             levels[s], i, filtered_out, f_prev);
                end
`endif
                f_prev = filtered_out;
            end
        end
    endtask

    task automatic test_charge_sat();
        logic signed [15:0] f_prev;
        longint step1;
        step1     = (longint'(32767) * a_lpf) >>> 16;
        reset     = 1'b1;
        strobe(1);
        reset     = 1'b0;
        v_control = 16'sd32767;
        strobe(1);
        n_vec++;
        if (out !== 16'sd32767) begin
            n_err++;
            $display("FAIL sat_first_out: got %0d expected 32767", out);
        end
`ifndef VCO_LPF_DC_BLOCK_EN
        n_vec++;
        if (filtered_out !== 16'(step1)) begin
            n_err++;
            $display("FAIL sat_step1: got %0d expected %0d", filtered_out, step1);
        end
`endif
        f_prev = filtered_out;
        for (int i = 0; i < 120; i++) begin
            strobe($urandom_range(0, 2));
            n_vec++;
            if (out !== 16'sd32767 || filtered_out !== 16'(m_filt())) begin
                n_err++;
                $display("FAIL sat_model[%0d]: got out=%0d filt=%0d expected out=32767 filt=%0d",
                         i, out, filtered_out, m_filt());
            end
`ifndef VCO_LPF_DC_BLOCK_EN
            n_vec++;
            if (filtered_out < f_prev) begin
                n_err++;
                $display("FAIL sat_rise[%0d]: got %0d expected >= %0d", i, filtered_out, f_prev);
            end
`endif
            f_prev = filtered_out;
        end
    endtask

    task automatic test_idle_and_reset();
        logic signed [15:0] h_out, h_filt;
        bit found = 1'b0;
        v_control = 16'($urandom_range(8000, 28000));
        for (int i = 0; i < 50; i++) strobe($urandom_range(0, 2));
        h_out  = out;
        h_filt = filtered_out;
        for (int i = 0; i < 100; i++) begin
            v_control = 16'($urandom_range(0, 32767));
            @(posedge clk);
            #1;
            n_vec++;
            if (out !== h_out || filtered_out !== h_filt) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got out=%0d filt=%0d expected out=%0d filt=%0d",
                         i, out, filtered_out, h_out, h_filt);
            end
        end
        v_control = 16'sd20000;
        for (int i = 0; i < 300 && !found; i++) begin
            strobe(1);
            if (m_chg && m_vcap > 2000) found = 1'b1;
        end
        n_vec++;
        if (!found || out !== 16'sd32767) begin
            n_err++;
            $display("FAIL mid_charge_reach: got out=%0d expected 32767 within 300 strobes", out);
        end
        reset = 1'b1;
        strobe(0);
        reset = 1'b0;
        n_vec++;
        if (out !== 16'sd0 || filtered_out !== 16'sd0) begin
            n_err++;
            $display("FAIL mid_charge_reset: got out=%0d filt=%0d expected 0 0", out, filtered_out);
        end
        for (int i = 0; i < 40; i++) begin
            strobe($urandom_range(0, 2));
            n_vec++;
            if (out !== 16'(m_out) || filtered_out !== 16'(m_filt())) begin
                n_err++;
                $display("FAIL after_reset[%0d]: got out=%0d filt=%0d expected out=%0d filt=%0d",
                         i, out, filtered_out, m_out, m_filt());
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                v_control = 16'(int'($urandom_range(0, 34767)) - 2000 > 32767 ?
                                32767 : int'($urandom_range(0, 34767)) - 2000);
                hold = $urandom_range(20, 200);
            end
            hold--;
            reset = ($urandom_range(0, 499) == 0);
            strobe($urandom_range(0, 3));
            reset = 1'b0;
            n_vec++;
            if (out !== 16'(m_out) || filtered_out !== 16'(m_filt())) begin
                n_err++;
                $display("FAIL random[%0d] vctl=%0d: got out=%0d filt=%0d expected out=%0d filt=%0d",
                         i, v_control, out, filtered_out, m_out, m_filt());
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion expected finish before 5 ms");
        $fatal(1, "simulation time limit");
    end

    // ---------------- sequence and report ----------------
    initial begin
        reset        = 1'b1;
        audio_clk_en = 1'b0;
        v_control    = 16'sd0;
        model_coefs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_period();
        test_sweep();
        test_halt();
        test_charge_sat();
        test_idle_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
